// File: rtl/pipe_dot_pe.sv
// Pipelined signed dot-product engine: LANES multipliers, an adder tree and a
// saturating accumulator that chains sub-vector beats into one result per vector.
module pipe_dot_pe #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [LANES*DW-1:0]      neuron,
    input  logic [LANES*DW-1:0]      weight,
    input  logic                     first,
    input  logic                     last,
    input  logic                     relu_en,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic signed [AW-1:0]     result,
    output logic                     ovf
);
    localparam int PW = 2 * DW;
    localparam int SW = PW + $clog2(LANES);
    localparam int EW = ((AW > SW) ? AW : SW) + 1;

    logic                 stall;
    logic signed [PW-1:0] prod_c [LANES];
    logic signed [SW-1:0] tree_sum;

    logic                 s1_vld, s1_first, s1_last, s1_relu;
    logic signed [PW-1:0] s1_prod [LANES];
    logic                 s2_vld, s2_first, s2_last, s2_relu;
    logic signed [SW-1:0] s2_sum;
    logic                 s3_vld, s3_first, s3_last, s3_relu;
    logic signed [SW-1:0] s3_sum;

    logic signed [AW-1:0] psum;
    logic                 psum_ovf;
    logic                 new_vec;

    logic                 start;
    logic signed [EW-1:0] total, max_v, min_v;
    logic signed [AW-1:0] psum_nxt, res_nxt;
    logic                 ovf_nxt;

    // The only back-pressure point is a finished result that cannot leave.
    assign stall  = out_vld && !out_rdy && s3_vld && s3_last;
    assign in_rdy = !stall;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = PW'($signed(neuron[i*DW +: DW])) * PW'($signed(weight[i*DW +: DW]));
        end
    end

    // Tree is sized to the full product growth, so a beat sum never wraps even
    // when AW is narrower; clipping happens once, in the accumulator.
    always_comb begin
        logic signed [SW-1:0] node [2*LANES];
        node = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            node[LANES+i] = SW'(s1_prod[i]);
        end
        for (int i = LANES - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        tree_sum = node[1];
    end

    always_comb begin
        start    = s3_first || new_vec;
        total    = (start ? EW'(0) : EW'(psum)) + EW'(s3_sum);
        max_v    = '0;
        max_v[AW-2:0] = '1;
        min_v    = '1;
        min_v[AW-2:0] = '0;
        psum_nxt = total[AW-1:0];
        ovf_nxt  = start ? 1'b0 : psum_ovf;
        if (total > max_v) begin
            psum_nxt = max_v[AW-1:0];
            ovf_nxt  = 1'b1;
        end else if (total < min_v) begin
            psum_nxt = min_v[AW-1:0];
            ovf_nxt  = 1'b1;
        end
        res_nxt = (s3_relu && psum_nxt[AW-1]) ? '0 : psum_nxt;
    end

    // Whole pipeline advances together unless stalled; bubbles carry vld=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;  s1_first <= 1'b0;  s1_last <= 1'b0;  s1_relu <= 1'b0;
            s2_vld   <= 1'b0;  s2_first <= 1'b0;  s2_last <= 1'b0;  s2_relu <= 1'b0;
            s3_vld   <= 1'b0;  s3_first <= 1'b0;  s3_last <= 1'b0;  s3_relu <= 1'b0;
            for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
            s2_sum   <= '0;
            s3_sum   <= '0;
            psum     <= '0;
            psum_ovf <= 1'b0;
            new_vec  <= 1'b1;
            result   <= '0;
            ovf      <= 1'b0;
            out_vld  <= 1'b0;
        end else if (!stall) begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_first <= first;
                s1_last  <= last;
                s1_relu  <= relu_en;
                s1_prod  <= prod_c;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_relu  <= s1_relu;
                s2_sum   <= tree_sum;
            end
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_first <= s2_first;
                s3_last  <= s2_last;
                s3_relu  <= s2_relu;
                s3_sum   <= s2_sum;
            end
            if (s3_vld) begin
                psum     <= psum_nxt;
                psum_ovf <= ovf_nxt;
                new_vec  <= s3_last;
            end
            if (s3_vld && s3_last) begin
                result  <= res_nxt;
                ovf     <= ovf_nxt;
                out_vld <= 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_dot_pe.sv
// Scoreboard bench for pipe_dot_pe: a plain-arithmetic vector model queues the
// expected results, a negedge monitor pops them whenever a result is accepted.
module tb_pipe_dot_pe;
    localparam int LANES = 32;
    localparam int DW    = 16;
    localparam int AW    = 32;

    typedef struct {
        longint res;
        bit     ovf;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_vld;
    logic                 in_rdy;
    logic [LANES*DW-1:0]  neuron;
    logic [LANES*DW-1:0]  weight;
    logic                 first;
    logic                 last;
    logic                 relu_en;
    logic                 out_vld;
    logic                 out_rdy;
    logic signed [AW-1:0] result;
    logic                 ovf;

    int     tests = 0;
    int     failures = 0;
    int     rdyMode = 0;
    exp_t   expQ[$];
    longint mPsum;
    bit     mOvf;
    bit     mNew;

    pipe_dot_pe #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .neuron(neuron), .weight(weight), .first(first), .last(last),
        .relu_en(relu_en), .out_vld(out_vld), .out_rdy(out_rdy),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // out_rdy policy: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdyMode)
                1:       out_rdy = ($urandom_range(0, 3) != 0);
                2:       out_rdy = 1'b0;
                default: out_rdy = 1'b1;
            endcase
        end
    end

    task automatic modelReset();
        mPsum = 0;
        mOvf  = 1'b0;
        mNew  = 1'b1;
    endtask

    // Reference: exact beat dot product, clamped running sum per vector.
    task automatic modelBeat(input logic [LANES*DW-1:0] n, input logic [LANES*DW-1:0] w,
                             input bit f, input bit l, input bit r);
        longint s, t, maxV, minV;
        logic signed [DW-1:0] a, b;
        exp_t e;
        maxV = (longint'(1) << (AW - 1)) - 1;
        minV = -(longint'(1) << (AW - 1));
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            a = n[i*DW +: DW];
            b = w[i*DW +: DW];
            s += longint'(a) * longint'(b);
        end
        if (f || mNew) begin
            mPsum = 0;
            mOvf  = 1'b0;
        end
        t = mPsum + s;
        if (t > maxV) begin t = maxV; mOvf = 1'b1; end
        if (t < minV) begin t = minV; mOvf = 1'b1; end
        mPsum = t;
        mNew  = l;
        if (l) begin
            e.res = (r && t < 0) ? 0 : t;
            e.ovf = mOvf;
            expQ.push_back(e);
        end
    endtask

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [LANES*DW-1:0] n, input logic [LANES*DW-1:0] w,
                                 input bit f, input bit l, input bit r);
        bit acc = 1'b0;
        int waitCnt = 0;
        neuron = n; weight = w; first = f; last = l; relu_en = r; in_vld = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            if (!acc) begin
                waitCnt++;
                if (waitCnt > 200) begin
                    failures++;
                    $display("[TB] FAIL in_rdy_timeout: got in_rdy=0 for %0d cycles, expected 1", waitCnt);
                    $display("[TB] %0d tests run, %0d failed", tests, failures);
                    $fatal(1, "[TB] stuck on back-pressure");
                end
            end
        end
        modelBeat(n, w, f, l, r);
    endtask

    task automatic idleCycle();
        in_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int c = 0;
        in_vld = 1'b0;
        while ((expQ.size() != 0 || out_vld) && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_pending", expQ.size(), 0);
    endtask

    function automatic logic [LANES*DW-1:0] fill(input int v, input int cnt);
        logic [LANES*DW-1:0] x = '0;
        for (int i = 0; i < cnt; i++) x[i*DW +: DW] = DW'(v);
        return x;
    endfunction

    // Monitor: compares accepted results in order and checks hold stability.
    initial begin
        exp_t e;
        bit held = 1'b0;
        logic signed [AW-1:0] hRes;
        logic hOvf;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                check("hold_vld", out_vld, 1);
                check("hold_result", result, hRes);
                check("hold_ovf", ovf, hOvf);
            end
            held = out_vld && !out_rdy;
            hRes = result;
            hOvf = ovf;
            if (out_vld && out_rdy) begin
                if (expQ.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    check("result", result, e.res);
                    check("ovf", ovf, e.ovf);
                end
            end
        end
    end

    initial begin
        logic [LANES*DW-1:0] n, w;
        int lat, tmp;
        rst_n = 1'b0; in_vld = 1'b0; neuron = '0; weight = '0;
        first = 1'b0; last = 1'b0; relu_en = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_vld", out_vld, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;

        // One-beat vector: latency and single-cycle valid.
        applyStimulus(fill(1, LANES), fill(2, LANES), 1, 1, 0);
        in_vld = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_vld) begin lat = c; break; end
        end
        check("latency", lat, 4);
        @(negedge clk);
        check("vld_one_cycle", out_vld, 0);
        @(posedge clk);
        #1;

        // Four-beat vector then a fresh vector with no carry-over.
        for (int b = 0; b < 4; b++) applyStimulus(fill(5, 1), fill(2, 1), b == 0, b == 3, 0);
        applyStimulus(fill(3, 1), fill(1, 1), 1, 1, 0);
        // Saturating vector followed by a clean one.
        for (int b = 0; b < 2; b++) applyStimulus(fill(-32768, LANES), fill(-32768, LANES), b == 0, b == 1, 0);
        applyStimulus(fill(4, 2), fill(1, 2), 1, 1, 0);
        // ReLU on and off for a negative sum.
        applyStimulus(fill(-5, 1), fill(1, 1), 1, 1, 1);
        applyStimulus(fill(-5, 1), fill(1, 1), 1, 1, 0);
        waitDrain();

        // Back-pressure: two one-beat vectors against a blocked output.
        rdyMode = 2;
        idleCycle();
        applyStimulus(fill(1, 3), fill(7, 3), 1, 1, 0);
        applyStimulus(fill(-2, 4), fill(3, 4), 1, 1, 0);
        repeat (5) idleCycle();
        @(negedge clk);
        check("stall_in_rdy", in_rdy, 0);
        @(posedge clk);
        #1;
        rdyMode = 0;
        waitDrain();

        // Reset in the middle of a vector discards the partial sum.
        for (int b = 0; b < 2; b++) applyStimulus(fill(100, LANES), fill(9, LANES), b == 0, 1'b0, 0);
        in_vld = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("midreset_out_vld", out_vld, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        check("midreset_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
        applyStimulus(fill(7, 1), fill(3, 1), 0, 1, 0);
        waitDrain();

        // Randomized vectors, bubbles and random back-pressure.
        rdyMode = 1;
        for (int v = 0; v < 60; v++) begin
            int len, kind;
            bit relu;
            len  = $urandom_range(1, 5);
            kind = $urandom_range(0, 9);
            relu = $urandom_range(0, 1);
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < LANES; i++) begin
                    if (kind == 0) begin
                        n[i*DW +: DW] = DW'(-32768);
                        w[i*DW +: DW] = DW'(-32768);
                    end else if (kind < 4) begin
                        n[i*DW +: DW] = DW'($urandom);
                        w[i*DW +: DW] = DW'($urandom);
                    end else begin
                        tmp = $urandom_range(0, 255);
                        n[i*DW +: DW] = DW'(tmp - 128);
                        tmp = $urandom_range(0, 255);
                        w[i*DW +: DW] = DW'(tmp - 128);
                    end
                end
                applyStimulus(n, w, (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0, b == len - 1, relu);
                if ($urandom_range(0, 3) == 0) idleCycle();
            end
        end
        rdyMode = 0;
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
